// File: rtl/e203_ifu_jalr_sched.sv
// IFU branch-prediction sequencer: static taken prediction, target-adder operands,
// and scheduling of the JALR rs1 operand through x0, the x1 path, or a borrowed regfile port.
module e203_ifu_jalr_sched #(
  parameter int XLEN    = 32,
  parameter int PC_SIZE = 32,
  parameter int RFIDX_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dec_valid,
  input  logic               dec_jal,
  input  logic               dec_jalr,
  input  logic               dec_bxx,
  input  logic [RFIDX_W-1:0] dec_jalr_rs1idx,
  input  logic [XLEN-1:0]    dec_bjp_imm,
  input  logic [PC_SIZE-1:0] pc,
  input  logic               bpu_fire,
  input  logic               flush,
  input  logic               oitf_empty,
  input  logic               ir_valid,
  input  logic               ir_rs1en,
  input  logic               ir_rdwen,
  input  logic [RFIDX_W-1:0] ir_rdidx,
  input  logic [XLEN-1:0]    rf2bpu_x1,
  input  logic [XLEN-1:0]    rf2bpu_rs1,
  output logic               bpu2rf_rs1_ena,
  output logic               bpu_wait,
  output logic               prdt_taken,
  output logic [PC_SIZE-1:0] prdt_op1,
  output logic [PC_SIZE-1:0] prdt_op2
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RDRF,
    S_HOLD
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_rs1_buf;

  logic w_jal;
  logic w_jalr;
  logic w_bxx;
  logic w_jx0;
  logic w_jx1;
  logic w_jxn;
  logic w_x1_dep;
  logic w_xn_dep;
  logic w_port_free;
  logic w_rs1_ena;

  assign w_jal  = dec_valid & dec_jal;
  assign w_jalr = dec_valid & dec_jalr;
  assign w_bxx  = dec_valid & dec_bxx;
  assign w_jx0  = w_jalr & (dec_jalr_rs1idx == RFIDX_W'(0));
  assign w_jx1  = w_jalr & (dec_jalr_rs1idx == RFIDX_W'(1));
  assign w_jxn  = w_jalr & (dec_jalr_rs1idx > RFIDX_W'(1));

  // Any instruction sitting in IR might overwrite an arbitrary rs1, so xn is conservative.
  assign w_x1_dep    = ~oitf_empty | (ir_valid & ir_rdwen & (ir_rdidx == RFIDX_W'(1)));
  assign w_xn_dep    = ~oitf_empty | ir_valid;
  assign w_port_free = ~(ir_valid & ir_rs1en);

  assign w_rs1_ena = (r_state == S_IDLE) & w_jxn & ~w_xn_dep & w_port_free & ~flush;

  assign bpu2rf_rs1_ena = w_rs1_ena;
  assign bpu_wait       = (w_jx1 & w_x1_dep) | (w_jxn & (r_state != S_HOLD));
  assign prdt_taken     = w_jal | w_jalr | (w_bxx & dec_bjp_imm[XLEN-1]);
  assign prdt_op2       = dec_valid ? PC_SIZE'($signed(dec_bjp_imm)) : '0;

  always_comb begin
    prdt_op1 = '0;
    if (w_jal | w_bxx) begin
      prdt_op1 = pc;
    end else if (w_jx1) begin
      prdt_op1 = PC_SIZE'(rf2bpu_x1);
    end else if (w_jxn) begin
      prdt_op1 = PC_SIZE'(r_rs1_buf);
    end
  end

  // Flush beats everything, then a vanished instruction, then the normal request/latch/hold walk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rs1_buf <= '0;
    end else if (flush || !dec_valid) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_rs1_ena) r_state <= S_RDRF;
        S_RDRF: begin
          r_rs1_buf <= rf2bpu_rs1;
          r_state   <= S_HOLD;
        end
        S_HOLD: if (bpu_fire) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_e203_ifu_jalr_sched.sv
// Directed table-driven bench for e203_ifu_jalr_sched, plus hand sequences for the
// multi-cycle rs1 request/latch/hold paths, flush and reset.
module tb_e203_ifu_jalr_sched;

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic        jal;
    logic        jalr;
    logic        bxx;
    logic [4:0]  rs1idx;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        fire;
    logic        flush;
    logic        oitf_empty;
    logic        ir_valid;
    logic        ir_rs1en;
    logic        ir_rdwen;
    logic [4:0]  ir_rdidx;
    logic [31:0] x1;
    logic [31:0] rs1;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        taken;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        bwait;
    logic        ena;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        dec_valid, dec_jal, dec_jalr, dec_bxx;
  logic [4:0]  dec_jalr_rs1idx;
  logic [31:0] dec_bjp_imm, pc;
  logic        bpu_fire, flush, oitf_empty, ir_valid, ir_rs1en, ir_rdwen;
  logic [4:0]  ir_rdidx;
  logic [31:0] rf2bpu_x1, rf2bpu_rs1;
  logic        bpu2rf_rs1_ena, bpu_wait, prdt_taken;
  logic [31:0] prdt_op1, prdt_op2;

  int checks = 0;
  int errors = 0;
  vec_t vq[$];

  e203_ifu_jalr_sched dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_jal(dec_jal), .dec_jalr(dec_jalr), .dec_bxx(dec_bxx),
    .dec_jalr_rs1idx(dec_jalr_rs1idx), .dec_bjp_imm(dec_bjp_imm), .pc(pc),
    .bpu_fire(bpu_fire), .flush(flush), .oitf_empty(oitf_empty),
    .ir_valid(ir_valid), .ir_rs1en(ir_rs1en), .ir_rdwen(ir_rdwen), .ir_rdidx(ir_rdidx),
    .rf2bpu_x1(rf2bpu_x1), .rf2bpu_rs1(rf2bpu_rs1),
    .bpu2rf_rs1_ena(bpu2rf_rs1_ena), .bpu_wait(bpu_wait), .prdt_taken(prdt_taken),
    .prdt_op1(prdt_op1), .prdt_op2(prdt_op2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t idleStim();
    stim_t s;
    s = '{default: '0};
    s.rst_n      = 1'b1;
    s.oitf_empty = 1'b1;
    return s;
  endfunction

  function automatic stim_t jalrStim(input logic [4:0] idx);
    stim_t s;
    s = idleStim();
    s.valid  = 1'b1;
    s.jalr   = 1'b1;
    s.rs1idx = idx;
    s.imm    = 32'h0000_0040;
    s.pc     = 32'h8000_0300;
    s.x1     = 32'h1234_5678;
    return s;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1ns later, well clear of the rising edge.
  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    rst_n           = s.rst_n;
    dec_valid       = s.valid;
    dec_jal         = s.jal;
    dec_jalr        = s.jalr;
    dec_bxx         = s.bxx;
    dec_jalr_rs1idx = s.rs1idx;
    dec_bjp_imm     = s.imm;
    pc              = s.pc;
    bpu_fire        = s.fire;
    flush           = s.flush;
    oitf_empty      = s.oitf_empty;
    ir_valid        = s.ir_valid;
    ir_rs1en        = s.ir_rs1en;
    ir_rdwen        = s.ir_rdwen;
    ir_rdidx        = s.ir_rdidx;
    rf2bpu_x1       = s.x1;
    rf2bpu_rs1      = s.rs1;
    #1;
  endtask

  task automatic checkOutput(input string nm, input logic taken, input logic [31:0] op1,
                             input logic [31:0] op2, input logic bwait, input logic ena);
    checks++;
    if (prdt_taken !== taken || prdt_op1 !== op1 || prdt_op2 !== op2 ||
        bpu_wait !== bwait || bpu2rf_rs1_ena !== ena) begin
      errors++;
      $display("[TB] FAIL %s: got taken=%b op1=%h op2=%h wait=%b ena=%b, want taken=%b op1=%h op2=%h wait=%b ena=%b",
               nm, prdt_taken, prdt_op1, prdt_op2, bpu_wait, bpu2rf_rs1_ena,
               taken, op1, op2, bwait, ena);
    end
  endtask

  task automatic addVec(input stim_t s, input logic taken, input logic [31:0] op1,
                        input logic [31:0] op2, input logic bwait, input logic ena);
    vec_t v;
    v.s = s; v.taken = taken; v.op1 = op1; v.op2 = op2; v.bwait = bwait; v.ena = ena;
    vq.push_back(v);
  endtask

  initial begin
    stim_t s;

    // Table of single-cycle vectors; none of them issues a request, so the FSM stays idle.
    s = idleStim();
    addVec(s, 0, 32'h0, 32'h0, 0, 0);
    s = idleStim(); s.valid = 1; s.jal = 1; s.pc = 32'h8000_0100; s.imm = 32'h0000_0020;
    addVec(s, 1, 32'h8000_0100, 32'h0000_0020, 0, 0);
    s = idleStim(); s.valid = 1; s.bxx = 1; s.pc = 32'h8000_0200; s.imm = 32'hFFFF_FFF0;
    addVec(s, 1, 32'h8000_0200, 32'hFFFF_FFF0, 0, 0);
    s = idleStim(); s.valid = 1; s.bxx = 1; s.pc = 32'h8000_0200; s.imm = 32'h0000_0010;
    addVec(s, 0, 32'h8000_0200, 32'h0000_0010, 0, 0);
    s = jalrStim(5'd0); s.imm = 32'h0000_0004;
    addVec(s, 1, 32'h0, 32'h0000_0004, 0, 0);
    s = jalrStim(5'd0); s.oitf_empty = 0; s.ir_valid = 1;
    addVec(s, 1, 32'h0, 32'h0000_0040, 0, 0);
    s = jalrStim(5'd1);
    addVec(s, 1, 32'h1234_5678, 32'h0000_0040, 0, 0);
    s = jalrStim(5'd1); s.ir_valid = 1; s.ir_rdwen = 1; s.ir_rdidx = 5'd1;
    addVec(s, 1, 32'h1234_5678, 32'h0000_0040, 1, 0);
    s = jalrStim(5'd1); s.ir_valid = 1; s.ir_rdwen = 1; s.ir_rdidx = 5'd2;
    addVec(s, 1, 32'h1234_5678, 32'h0000_0040, 0, 0);
    s = jalrStim(5'd1); s.oitf_empty = 0;
    addVec(s, 1, 32'h1234_5678, 32'h0000_0040, 1, 0);
    s = jalrStim(5'd5); s.oitf_empty = 0;
    addVec(s, 1, 32'h0, 32'h0000_0040, 1, 0);
    s = jalrStim(5'd5); s.ir_valid = 1;
    addVec(s, 1, 32'h0, 32'h0000_0040, 1, 0);
    s = jalrStim(5'd5); s.flush = 1;
    addVec(s, 1, 32'h0, 32'h0000_0040, 1, 0);
    s = idleStim(); s.jal = 1; s.jalr = 1; s.bxx = 1; s.rs1idx = 5'd5; s.imm = 32'hFFFF_FFF0; s.pc = 32'h8000_0100;
    addVec(s, 0, 32'h0, 32'h0, 0, 0);
    s = idleStim(); s.valid = 1; s.jal = 1; s.pc = 32'h8000_0400; s.imm = 32'hFFFF_FF00;
    s.oitf_empty = 0; s.ir_valid = 1; s.ir_rdwen = 1; s.ir_rdidx = 5'd1;
    addVec(s, 1, 32'h8000_0400, 32'hFFFF_FF00, 0, 0);

    // Reset
    s = idleStim(); s.rst_n = 0;
    applyStimulus(s);
    applyStimulus(s);
    checkOutput("reset", 0, 32'h0, 32'h0, 0, 0);
    s = idleStim();
    applyStimulus(s);
    checkOutput("post_reset", 0, 32'h0, 32'h0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      applyStimulus(vq[i].s);
      checkOutput($sformatf("vec%0d", i), vq[i].taken, vq[i].op1, vq[i].op2, vq[i].bwait, vq[i].ena);
    end

    // JALR x1 held off by an IR write to x1 for three cycles
    for (int i = 0; i < 3; i++) begin
      s = jalrStim(5'd1); s.ir_valid = 1; s.ir_rdwen = 1; s.ir_rdidx = 5'd1;
      applyStimulus(s);
      checkOutput($sformatf("x1_dep%0d", i), 1, 32'h1234_5678, 32'h0000_0040, 1, 0);
    end
    s = jalrStim(5'd1); s.fire = 1;
    applyStimulus(s);
    checkOutput("x1_go", 1, 32'h1234_5678, 32'h0000_0040, 0, 0);

    // JALR x5 on an idle pipeline: request, latch, hold until fire
    s = jalrStim(5'd5); s.rs1 = 32'h5555_5555;
    applyStimulus(s);
    checkOutput("x5_req", 1, 32'h0, 32'h0000_0040, 1, 1);
    s.rs1 = 32'hDEAD_BEE0;
    applyStimulus(s);
    checkOutput("x5_latch", 1, 32'h0, 32'h0000_0040, 1, 0);
    s.rs1 = 32'h0;
    applyStimulus(s);
    checkOutput("x5_hold0", 1, 32'hDEAD_BEE0, 32'h0000_0040, 0, 0);
    s.fire = 1;
    applyStimulus(s);
    checkOutput("x5_hold_fire", 1, 32'hDEAD_BEE0, 32'h0000_0040, 0, 0);
    s.fire = 0; s.oitf_empty = 0;
    applyStimulus(s);
    checkOutput("x5_back_idle", 1, 32'hDEAD_BEE0, 32'h0000_0040, 1, 0);

    // JALR x5 stalled by OITF, then by a port conflict, then a single request
    for (int i = 0; i < 4; i++) begin
      s = jalrStim(5'd5); s.oitf_empty = 0;
      applyStimulus(s);
      checkOutput($sformatf("stall_oitf%0d", i), 1, 32'hDEAD_BEE0, 32'h0000_0040, 1, 0);
    end
    s = jalrStim(5'd5); s.ir_valid = 1; s.ir_rs1en = 1;
    applyStimulus(s);
    checkOutput("stall_port", 1, 32'hDEAD_BEE0, 32'h0000_0040, 1, 0);
    s = jalrStim(5'd5);
    applyStimulus(s);
    checkOutput("stall_req", 1, 32'hDEAD_BEE0, 32'h0000_0040, 1, 1);
    s.rs1 = 32'hCAFE_0000;
    applyStimulus(s);
    checkOutput("stall_latch", 1, 32'hDEAD_BEE0, 32'h0000_0040, 1, 0);
    s.rs1 = 32'h0; s.fire = 1;
    applyStimulus(s);
    checkOutput("stall_hold", 1, 32'hCAFE_0000, 32'h0000_0040, 0, 0);
    s = idleStim();
    applyStimulus(s);
    checkOutput("stall_done", 0, 32'h0, 32'h0, 0, 0);

    // Flush in RDRF, fresh request, then flush together with fire in HOLD
    s = jalrStim(5'd6);
    applyStimulus(s);
    checkOutput("fl_req", 1, 32'hCAFE_0000, 32'h0000_0040, 1, 1);
    s.flush = 1; s.rs1 = 32'h1111_1110;
    applyStimulus(s);
    checkOutput("fl_rdrf", 1, 32'hCAFE_0000, 32'h0000_0040, 1, 0);
    s.flush = 0;
    applyStimulus(s);
    checkOutput("fl_rereq", 1, 32'hCAFE_0000, 32'h0000_0040, 1, 1);
    s.rs1 = 32'h2222_2220;
    applyStimulus(s);
    checkOutput("fl_latch", 1, 32'hCAFE_0000, 32'h0000_0040, 1, 0);
    s.rs1 = 32'h0; s.flush = 1; s.fire = 1;
    applyStimulus(s);
    checkOutput("fl_hold", 1, 32'h2222_2220, 32'h0000_0040, 0, 0);
    s.flush = 0; s.fire = 0; s.oitf_empty = 0;
    applyStimulus(s);
    checkOutput("fl_idle", 1, 32'h2222_2220, 32'h0000_0040, 1, 0);

    // Instruction disappearing in HOLD without fire drops back to IDLE
    s = jalrStim(5'd7);
    applyStimulus(s);
    s.rs1 = 32'h4444_4440;
    applyStimulus(s);
    s.rs1 = 32'h0;
    applyStimulus(s);
    checkOutput("nv_hold", 1, 32'h4444_4440, 32'h0000_0040, 0, 0);
    s = idleStim();
    applyStimulus(s);
    checkOutput("nv_gone", 0, 32'h0, 32'h0, 0, 0);
    s = jalrStim(5'd7); s.oitf_empty = 0;
    applyStimulus(s);
    checkOutput("nv_idle", 1, 32'h4444_4440, 32'h0000_0040, 1, 0);

    // Reset while in HOLD clears both state and the operand buffer
    s = jalrStim(5'd5);
    applyStimulus(s);
    s.rs1 = 32'h3333_3330;
    applyStimulus(s);
    s.rs1 = 32'h0;
    applyStimulus(s);
    checkOutput("rst_hold", 1, 32'h3333_3330, 32'h0000_0040, 0, 0);
    s.rst_n = 0;
    applyStimulus(s);
    s.rst_n = 1; s.oitf_empty = 0;
    applyStimulus(s);
    checkOutput("rst_after", 1, 32'h0, 32'h0000_0040, 1, 0);
    s.oitf_empty = 1;
    applyStimulus(s);
    checkOutput("rst_rereq", 1, 32'h0, 32'h0000_0040, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/e203_ifu_jalr_sched.md
Name: e203_ifu_jalr_sched

Overview:
- Branch-prediction sequencer in the IFU, downstream of the IFU mini-decoder.
- Consumes the mini-decoded jump/branch info of the instruction being fetched and produces a static taken prediction plus target-adder operands.
- Schedules the JALR rs1 source:
  - x0 gives zero.
  - x1 comes from the dedicated x1 path.
  - Any other register comes from one borrowed regfile read port, via a request/latch state machine with dependency stalls.

Parameters:
- XLEN, 32, data/immediate width
- PC_SIZE, 32, PC width
- RFIDX_W, 5, register index width

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- dec_valid  in  1  mini-decoded instruction valid this cycle
- dec_jal  in  1  instruction is JAL
- dec_jalr  in  1  instruction is JALR
- dec_bxx  in  1  instruction is conditional branch
- dec_jalr_rs1idx  in  RFIDX_W  JALR rs1 index
- dec_bjp_imm  in  XLEN  branch/jump immediate, sign-extended
- pc  in  PC_SIZE  PC of decoded instruction
- bpu_fire  in  1  IFU consumes the prediction this cycle
- flush  in  1  pipeline flush, abandons the current sequence
- oitf_empty  in  1  no outstanding long-pipe writes
- ir_valid  in  1  IR stage holds a valid instruction
- ir_rs1en  in  1  IR instruction uses regfile read port 1
- ir_rdwen  in  1  IR instruction writes rd
- ir_rdidx  in  RFIDX_W  IR instruction rd index
- rf2bpu_x1  in  XLEN  live x1 value
- rf2bpu_rs1  in  XLEN  regfile port-1 data, valid the cycle after the request
- bpu2rf_rs1_ena  out  1  one-cycle request to steer port 1 to dec_jalr_rs1idx
- bpu_wait  out  1  prediction not ready; IFU must hold
- prdt_taken  out  1  predicted taken
- prdt_op1  out  PC_SIZE  target adder operand 1
- prdt_op2  out  PC_SIZE  target adder operand 2

Behaviour:
- Classification, only while dec_valid=1:
  - jx0 = jalr and rs1idx==0
  - jx1 = jalr and rs1idx==1
  - jxn = jalr and rs1idx>1
- Prediction is combinational:
  - prdt_taken = jal | jalr | (bxx & dec_bjp_imm[XLEN-1]), i.e. backward branches are taken.
  - prdt_op2 = dec_bjp_imm (truncated/extended to PC_SIZE).
  - prdt_op1 = pc for jal/bxx; 0 for jx0; rf2bpu_x1 for jx1; rs1_buf for jxn.
  - All outputs are 0 when dec_valid=0.
- x1 dependency: x1_dep = !oitf_empty | (ir_valid & ir_rdwen & ir_rdidx==1).
- xn dependency: xn_dep = !oitf_empty | ir_valid. Any IR instruction may write rs1.
- Port free: port_free = !(ir_valid & ir_rs1en).
- State machine, states IDLE, RDRF, HOLD, registered:
  - IDLE: if jxn & !xn_dep & port_free, assert bpu2rf_rs1_ena (combinational, this cycle) and go to RDRF. Otherwise stay.
  - RDRF: latch rs1_buf <= rf2bpu_rs1 and go to HOLD. bpu2rf_rs1_ena=0.
  - HOLD: go to IDLE on bpu_fire.
  - The request is issued at most once per instruction.
- bpu_wait is combinational:
  - jx1 & x1_dep, or
  - jxn & state!=HOLD.
  - Otherwise 0. jal, bxx and jx0 never wait.
- Latency for jxn with no dependency: request in cycle N, latch in N+1, bpu_wait=0 from N+2.
- Precedence: flush, then !dec_valid, then normal transitions.
  - flush=1 forces state to IDLE regardless of other inputs, including a simultaneous bpu_fire.
  - In RDRF or HOLD, dec_valid=0 without flush also returns to IDLE.
  - No request is issued in a flush cycle.
- bpu_fire in IDLE is legal only for non-waiting instructions and causes no state change.
- rs1_buf holds its value outside RDRF.
- Reset (rst_n=0 at a clock edge): state=IDLE, rs1_buf=0.
  - bpu2rf_rs1_ena=0 and bpu_wait=0 for dec_valid=0.
  - Reset mid-sequence (RDRF/HOLD) returns to IDLE; no request is reissued until the next qualifying cycle.

Test Plan:
- JAL: pc=0x8000_0100, imm=0x0000_0020 -> taken=1, op1=0x8000_0100, op2=0x20, wait=0, no ena.
- BXX: imm=0xFFFF_FFF0 -> taken=1. Then imm=0x10 -> taken=0. op1=pc in both cases, wait=0.
- JALR x1:
  - ir_valid=1, ir_rdwen=1, ir_rdidx=1 for 3 cycles -> wait=1 for 3 cycles.
  - IR clears -> wait=0, op1=rf2bpu_x1=0x1234_5678.
- JALR x5, idle pipeline: ena pulse in cycle N; rf2bpu_rs1=0xDEAD_BEE0 in N+1 -> wait=0 from N+2, op1=0xDEAD_BEE0, held until bpu_fire, then IDLE.
- JALR x5 with stalls:
  - oitf_empty=0 for 4 cycles -> no ena.
  - Then ir_valid=1, ir_rs1en=1 -> still no ena.
  - IR clears -> single ena, then normal completion.
- Flush/reset:
  - flush asserted in RDRF -> IDLE next cycle; if jxn persists, a fresh ena follows.
  - flush together with bpu_fire in HOLD -> IDLE.
  - rst_n=0 in HOLD -> IDLE, rs1_buf=0.
